bitserial_logic_unit: RTL and testbench

BITSERIAL_LOGIC_UNIT -- requirements
Module: bitserial_logic_unit

---
 rtl/bitserial_logic_pkg.sv | 21 ++
 rtl/bitserial_logic_unit_if.sv | 38 +++
 rtl/nand_gate_cell.sv | 43 ++++
 rtl/bitserial_logic_unit.sv | 118 +++++++++++
 tb/tb_bitserial_logic_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/bitserial_logic_pkg.sv
// rtl/bitserial_logic_pkg.sv - shared opcode and FSM state definitions for the bit-serial logic unit
package bitserial_logic_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NOTA = 3'd3,
        OP_NAND = 3'd4,
        OP_NOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_BUFA = 3'd7
    } op_e;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

endpackage

// File: rtl/bitserial_logic_unit_if.sv
// rtl/bitserial_logic_unit_if.sv - operation request/result handshake bundle
// master: drives in_valid, op, a, b, out_ready; slave: drives in_ready, out_valid, y (and zero
// when ZERO_FLAG_EN is defined).
interface bitserial_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
`ifdef ZERO_FLAG_EN
    logic             zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y, zero
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, y
    );
`endif
endinterface

// File: rtl/nand_gate_cell.sv
// rtl/nand_gate_cell.sv - one result bit of the logic unit built purely from 2-input NAND gates
// Ports: a_bit, b_bit - operand bits; op - opcode; y_bit - result bit.
// Opcodes 4..7 are the complements of 0..3 (NOT a complemented is BUF a), so the cell
// selects among AND/OR/XOR/NOT-a with op[1:0] and then conditionally inverts with op[2].
module nand_gate_cell (
    input  wire       a_bit,
    input  wire       b_bit,
    input  wire [2:0] op,
    output wire       y_bit
);
    wire n_a, n_b, n_ab, and_ab, or_ab, x_1, x_2, xor_ab;
    wire n_s0, n_s1, p_0, q_0, m_0, p_1, q_1, m_1, p_2, q_2, m_sel;
    wire n_mo, r_1, r_2;

    // base functions
    nand g_na   (n_a, a_bit, a_bit);
    nand g_nb   (n_b, b_bit, b_bit);
    nand g_nab  (n_ab, a_bit, b_bit);
    nand g_and  (and_ab, n_ab, n_ab);
    nand g_or   (or_ab, n_a, n_b);
    nand g_x1   (x_1, a_bit, n_ab);
    nand g_x2   (x_2, b_bit, n_ab);
    nand g_xor  (xor_ab, x_1, x_2);

    // 4:1 select on op[1:0]: {AND, OR} and {XOR, NOT a} pairs, then pair select
    nand g_ns0  (n_s0, op[0], op[0]);
    nand g_ns1  (n_s1, op[1], op[1]);
    nand g_p0   (p_0, and_ab, n_s0);
    nand g_q0   (q_0, or_ab, op[0]);
    nand g_m0   (m_0, p_0, q_0);
    nand g_p1   (p_1, xor_ab, n_s0);
    nand g_q1   (q_1, n_a, op[0]);
    nand g_m1   (m_1, p_1, q_1);
    nand g_p2   (p_2, m_0, n_s1);
    nand g_q2   (q_2, m_1, op[1]);
    nand g_m    (m_sel, p_2, q_2);

    // conditional inversion: y = m_sel XOR op[2]
    nand g_nmo  (n_mo, m_sel, op[2]);
    nand g_r1   (r_1, m_sel, n_mo);
    nand g_r2   (r_2, op[2], n_mo);
    nand g_y    (y_bit, r_1, r_2);
endmodule

// File: rtl/bitserial_logic_unit.sv
// rtl/bitserial_logic_unit.sv - bit-serial bitwise logic unit, LANES result bits per cycle
// Ports: clk, rst_n (async, active-low); bus (slave): in_valid/in_ready/op/a/b request,
// out_valid/out_ready/y result, plus zero (y==0, registered with y) when ZERO_FLAG_EN is defined.
// Parameters: WIDTH (>=2) operand width, LANES bits per cycle (WIDTH multiple of LANES).
module bitserial_logic_unit
    import bitserial_logic_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int LANES = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    bitserial_logic_unit_if.slave bus
);
    localparam int              N          = WIDTH / LANES;
    localparam int              CW         = $clog2(N + 1);
    localparam logic [CW-1:0]   LAST_CHUNK = CW'(N - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [LANES-1:0] lane_y;

    // Captured operands shift right by LANES each RUN cycle, so the cells always see
    // the next LSB-first chunk in the low LANES bits.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        nand_gate_cell u_cell (
            .a_bit (a_q[l]),
            .b_bit (b_q[l]),
            .op    (op_q),
            .y_bit (lane_y[l])
        );
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        y_d     = y_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    op_d    = bus.op;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_q >> LANES;
                b_d   = b_q >> LANES;
                // new chunk enters at the top; after N chunks chunk 0 sits at the LSBs
                res_d = res_q >> LANES;
                res_d[WIDTH-1 -: LANES] = lane_y;
                cnt_d = cnt_q + CW'(1);
                // y only moves on completion so partial results never show
                if (cnt_q == LAST_CHUNK) begin
                    y_d     = res_d;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            y_q     <= y_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.y         = y_q;

`ifdef ZERO_FLAG_EN
    logic zero_q, zero_d;

    assign zero_d = ~|y_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero_q <= 1'b1;
        end else begin
            zero_q <= zero_d;
        end
    end

    assign bus.zero = zero_q;
`endif
endmodule

// File: tb/tb_bitserial_logic_unit.sv
// tb/tb_bitserial_logic_unit.sv - self-checking bench for bitserial_logic_unit
module tb_bitserial_logic_unit;
    import bitserial_logic_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       in_valid_drv = 1'b0;
    logic       out_ready_drv = 1'b0;
    logic [7:0] a_drv = 8'h00;
    logic [7:0] b_drv = 8'h00;
    logic [2:0] op_drv = 3'd0;

    logic       obs_valid, obs_ready;
    logic [7:0] obs_y;
    logic       obs_zero;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    // three instances: sel 0 = WIDTH 8/LANES 1, sel 1 = WIDTH 8/LANES 4, sel 2 = WIDTH 2/LANES 1
    bitserial_logic_unit_if #(.WIDTH(8)) if_l1 ();
    bitserial_logic_unit_if #(.WIDTH(8)) if_l4 ();
    bitserial_logic_unit_if #(.WIDTH(2)) if_w2 ();

    bitserial_logic_unit #(.WIDTH(8), .LANES(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if_l1.slave));
    bitserial_logic_unit #(.WIDTH(8), .LANES(4)) u_l4 (.clk(clk), .rst_n(rst_n), .bus(if_l4.slave));
    bitserial_logic_unit #(.WIDTH(2), .LANES(1)) u_w2 (.clk(clk), .rst_n(rst_n), .bus(if_w2.slave));

    assign if_l1.in_valid  = in_valid_drv && (sel == 2'd0);
    assign if_l4.in_valid  = in_valid_drv && (sel == 2'd1);
    assign if_w2.in_valid  = in_valid_drv && (sel == 2'd2);
    assign if_l1.out_ready = out_ready_drv && (sel == 2'd0);
    assign if_l4.out_ready = out_ready_drv && (sel == 2'd1);
    assign if_w2.out_ready = out_ready_drv && (sel == 2'd2);
    assign if_l1.a = a_drv;
    assign if_l1.b = b_drv;
    assign if_l1.op = op_drv;
    assign if_l4.a = a_drv;
    assign if_l4.b = b_drv;
    assign if_l4.op = op_drv;
    assign if_w2.a = a_drv[1:0];
    assign if_w2.b = b_drv[1:0];
    assign if_w2.op = op_drv;

    always_comb begin
        obs_zero = 1'b0;
        case (sel)
            2'd0: begin
                obs_valid = if_l1.out_valid; obs_ready = if_l1.in_ready; obs_y = if_l1.y;
`ifdef ZERO_FLAG_EN
                obs_zero = if_l1.zero;
`endif
            end
            2'd1: begin
                obs_valid = if_l4.out_valid; obs_ready = if_l4.in_ready; obs_y = if_l4.y;
`ifdef ZERO_FLAG_EN
                obs_zero = if_l4.zero;
`endif
            end
            default: begin
                obs_valid = if_w2.out_valid; obs_ready = if_w2.in_ready; obs_y = {6'b0, if_w2.y};
`ifdef ZERO_FLAG_EN
                obs_zero = if_w2.zero;
`endif
            end
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, req);
    endtask

    // reference: plain bitwise operators per opcode, masked to the instance width
    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x,
                                         input logic [7:0] w, input logic [1:0] s);
        logic [7:0] r;
        case (o)
            3'd0: r = x & w;
            3'd1: r = x | w;
            3'd2: r = x ^ w;
            3'd3: r = ~x;
            3'd4: r = ~(x & w);
            3'd5: r = ~(x | w);
            3'd6: r = ~(x ^ w);
            default: r = x;
        endcase
        return (s == 2'd2) ? (r & 8'h03) : r;
    endfunction

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!obs_valid && lat < 40) begin
            @(posedge clk); lat++; @(negedge clk);
        end
    endtask

    // one full operation; noisy toggles in_valid/out_ready and operands while busy
    task automatic run_op(input logic [1:0] s, input logic [7:0] ia, input logic [7:0] ib,
                          input logic [2:0] iop, input logic [7:0] ey, input int elat,
                          input string tag, input bit noisy);
        logic [7:0] prev_y;
        int lat;
        int hold;
        sel = s; a_drv = ia; b_drv = ib; op_drv = iop;
        in_valid_drv = 1'b1; out_ready_drv = 1'b0;
        #1;
        prev_y = obs_y;
        check({tag, " in_ready_idle"}, obs_ready, 1);
        @(posedge clk);
        @(negedge clk);
        lat = 0;
        while (!obs_valid && lat < 40) begin
            a_drv = noisy ? 8'($urandom) : 8'h00;
            b_drv = 8'($urandom);
            op_drv = 3'($urandom);
            in_valid_drv = noisy ? 1'($urandom) : 1'b0;
            out_ready_drv = noisy ? 1'($urandom) : 1'b0;
            #1;
            check({tag, " y_no_partial"}, obs_y, prev_y);
            check({tag, " in_ready_busy"}, obs_ready, 0);
            @(posedge clk); lat++; @(negedge clk);
        end
        in_valid_drv = 1'b0; out_ready_drv = 1'b0;
        check({tag, " latency"}, lat, elat);
        check({tag, " y"}, obs_y, ey);
`ifdef ZERO_FLAG_EN
        check({tag, " zero"}, obs_zero, (ey == 8'h00));
`endif
        hold = noisy ? $urandom_range(0, 2) : 0;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); @(negedge clk);
            check({tag, " hold_valid"}, obs_valid, 1);
            check({tag, " hold_y"}, obs_y, ey);
        end
        out_ready_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready_drv = 1'b0;
        check({tag, " back_idle_valid"}, obs_valid, 0);
        check({tag, " back_idle_ready"}, obs_ready, 1);
        check({tag, " y_retained"}, obs_y, ey);
    endtask

    typedef struct {
        logic [1:0] s;
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        int         lat;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int lat;
        logic [1:0] rs;
        logic [7:0] ra, rb;
        logic [2:0] rop;

        tbl[0]  = '{2'd2, 8'h01, 8'h03, OP_AND,  8'h01, 2};
        tbl[1]  = '{2'd2, 8'h01, 8'h03, OP_OR,   8'h03, 2};
        tbl[2]  = '{2'd2, 8'h01, 8'h03, OP_XOR,  8'h02, 2};
        tbl[3]  = '{2'd2, 8'h01, 8'h03, OP_NOTA, 8'h02, 2};
        tbl[4]  = '{2'd2, 8'h01, 8'h03, OP_NAND, 8'h02, 2};
        tbl[5]  = '{2'd2, 8'h01, 8'h03, OP_NOR,  8'h00, 2};
        tbl[6]  = '{2'd2, 8'h01, 8'h03, OP_XNOR, 8'h01, 2};
        tbl[7]  = '{2'd2, 8'h01, 8'h03, OP_BUFA, 8'h01, 2};
        tbl[8]  = '{2'd0, 8'hA5, 8'h0F, OP_XOR,  8'hAA, 8};
        tbl[9]  = '{2'd1, 8'hA5, 8'h0F, OP_XOR,  8'hAA, 2};
        tbl[10] = '{2'd0, 8'h0F, 8'hF0, OP_OR,   8'hFF, 8};
        tbl[11] = '{2'd0, 8'hF0, 8'h0F, OP_AND,  8'h00, 8};
        tbl[12] = '{2'd0, 8'hF0, 8'h0F, OP_OR,   8'hFF, 8};
        tbl[13] = '{2'd1, 8'hF0, 8'h0F, OP_NOR,  8'h00, 2};

        // reset state of every instance
        repeat (2) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            check("reset out_valid", obs_valid, 0);
            check("reset in_ready", obs_ready, 1);
            check("reset y", obs_y, 0);
`ifdef ZERO_FLAG_EN
            check("reset zero", obs_zero, 1);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 14; i++) begin
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].y, tbl[i].lat,
                   $sformatf("vec%0d", i), 1'b0);
        end

        // backpressure: result held for 5 cycles, in_valid ignored meanwhile
        sel = 2'd0; a_drv = 8'hA5; b_drv = 8'h0F; op_drv = OP_XOR; in_valid_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_drv = 1'b0;
        wait_valid(lat);
        check("bp latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            in_valid_drv = 1'b1; a_drv = 8'($urandom); op_drv = OP_AND;
            @(posedge clk); @(negedge clk);
            check("bp valid", obs_valid, 1);
            check("bp y", obs_y, 8'hAA);
            check("bp in_ready", obs_ready, 0);
        end
        in_valid_drv = 1'b0; out_ready_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready_drv = 1'b0;
        check("bp idle valid", obs_valid, 0);
        check("bp idle ready", obs_ready, 1);

        // reset in the middle of a run
        sel = 2'd0; a_drv = 8'hA5; b_drv = 8'h0F; op_drv = OP_XOR; in_valid_drv = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid_drv = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst valid", obs_valid, 0);
        check("midrst y", obs_y, 0);
        check("midrst ready", obs_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(2'd0, 8'hFF, 8'h3C, OP_AND, 8'h3C, 8, "after_rst", 1'b0);

        // randomized operations against the reference model
        for (int i = 0; i < 45; i++) begin
            rs = 2'($urandom_range(0, 2));
            ra = 8'($urandom); rb = 8'($urandom); rop = 3'($urandom);
            run_op(rs, ra, rb, rop, model(rop, ra, rb, rs), (rs == 2'd0) ? 8 : 2,
                   $sformatf("rnd%0d", i), 1'b1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
endmodule
